magnitude_packer: RTL and testbench

- Collects per-tone, per-corner magnitude results from the `channel` DSP instances and packs them into sequenced AXI-Stream frames for the Ethernet framer.
- Generalises the fixed 8×32-bit flat bus driven by a single valid into a parametrised channel count with independent per-channel valids.
- Adds set alignment with timeout, decimation or accumulation, sequence numbering, and back-pressure-safe frame buffering.

---
 rtl/magnitude_packer.sv | 185 ++++++++++++++++++
 tb/tb_magnitude_packer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_packer.sv
// magnitude_packer: aligns per-channel magnitude samples into sets, decimates or
// accumulates them into groups, and streams each group as a sequenced AXI-Stream
// frame (header word followed by one word per channel).
module magnitude_packer #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEQ_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_CH-1:0]            s_tvalid,
  input  logic [7:0]                 cfg_decim,
  input  logic                       cfg_accum,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [15:0]                timeout_count,
  output logic [15:0]                dup_count,
  output logic [15:0]                drop_count
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned WW = $clog2(N_CH + 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                state_q, state_d;
  logic [N_CH-1:0]       pend_q, pend_d, pend_all;
  logic [DATA_WIDTH-1:0] hold_q [N_CH];
  logic [DATA_WIDTH-1:0] hold_d [N_CH];
  logic [DATA_WIDTH-1:0] buf_q  [N_CH];
  logic [DATA_WIDTH-1:0] buf_d  [N_CH];
  logic [7:0]            set_cnt_q, set_cnt_d, decim_q, decim_d, decim_eff;
  logic [TW-1:0]         timer_q, timer_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d, dup_cnt_q, dup_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [WW-1:0]         word_q, word_d, dup_n;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, header, next_word;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                  set_done, timeout_fire, fresh, commit;
  logic [DATA_WIDTH:0]   acc;
  logic [16:0]           dup_sum;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign timeout_count = tmo_cnt_q;
  assign dup_count     = dup_cnt_q;
  assign drop_count    = drop_cnt_q;

  // Capture stage: set alignment, timeout, hold update, group/commit tracking, status counters
  always_comb begin
    pend_all     = pend_q | s_tvalid;
    set_done     = &pend_all;
    timeout_fire = (|pend_q) && !set_done && (timer_q == TW'(TIMEOUT - 1));
    decim_eff    = decim_q;
    if (set_cnt_q == 8'd0) decim_eff = (cfg_decim == 8'd0) ? 8'd1 : cfg_decim;
    fresh  = !cfg_accum || (set_cnt_q == 8'd0) || timeout_fire;
    commit = set_done && (({1'b0, set_cnt_q} + 9'd1) == {1'b0, decim_eff});

    hold_d = hold_q;
    acc    = '0;
    dup_n  = '0;
    for (int i = 0; i < N_CH; i++) begin
      dup_n = dup_n + WW'(s_tvalid[i] & pend_q[i]);
      if (s_tvalid[i]) begin
        acc = {1'b0, hold_q[i]} + {1'b0, s_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
        if (fresh) hold_d[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        else       hold_d[i] = acc[DATA_WIDTH] ? '1 : acc[DATA_WIDTH-1:0];
      end
    end

    pend_d    = pend_all;
    set_cnt_d = set_cnt_q;
    timer_d   = '0;
    if (set_done) begin
      pend_d    = '0;
      set_cnt_d = commit ? 8'd0 : set_cnt_q + 8'd1;
    end else if (timeout_fire) begin
      // abandon the group; a valid in this cycle opens the next set
      pend_d    = s_tvalid;
      set_cnt_d = '0;
    end else if (|pend_q) begin
      timer_d = timer_q + TW'(1);
    end
    decim_d = decim_eff;

    seq_d      = commit ? seq_q + SEQ_WIDTH'(1) : seq_q;
    tmo_cnt_d  = (timeout_fire && tmo_cnt_q != 16'hFFFF) ? tmo_cnt_q + 16'd1 : tmo_cnt_q;
    dup_sum    = {1'b0, dup_cnt_q} + 17'(dup_n);
    dup_cnt_d  = dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
    drop_cnt_d = (commit && state_q == S_SEND && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1
                                                                          : drop_cnt_q;
  end

  // Frame FSM: header then channel words, held stable while stalled
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    word_d   = word_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;

    header = '0;
    header[DATA_WIDTH-1 -: SEQ_WIDTH] = seq_q;
    header[7:0] = decim_eff;

    next_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (word_q == WW'(i)) next_word = buf_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (commit) begin
          buf_d    = hold_d;
          tdata_d  = header;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          word_d   = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            tdata_d = next_word;
            tlast_d = (word_q == WW'(N_CH - 1));
            word_d  = word_q + WW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
        buf_q[i]  <= '0;
      end
      set_cnt_q  <= '0;
      decim_q    <= '0;
      timer_q    <= '0;
      seq_q      <= '0;
      tmo_cnt_q  <= '0;
      dup_cnt_q  <= '0;
      drop_cnt_q <= '0;
      word_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      buf_q      <= buf_d;
      set_cnt_q  <= set_cnt_d;
      decim_q    <= decim_d;
      timer_q    <= timer_d;
      seq_q      <= seq_d;
      tmo_cnt_q  <= tmo_cnt_d;
      dup_cnt_q  <= dup_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      word_q     <= word_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

endmodule

// File: tb/tb_magnitude_packer.sv
// Bench for magnitude_packer: directed vector table, corner sequences and a
// randomized run against a set/group level reference model.
module tb_magnitude_packer;

  localparam int unsigned N_CH = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = 16;
  localparam int unsigned TMO  = 64;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic                 aclk = 1'b0;
  logic                 areset;
  logic [N_CH*DW-1:0]   s_tdata;
  logic [N_CH-1:0]      s_tvalid;
  logic [7:0]           cfg_decim;
  logic                 cfg_accum;
  logic [DW-1:0]        m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic [15:0]          timeout_count, dup_count, drop_count;

  magnitude_packer #(.N_CH(N_CH), .DATA_WIDTH(DW), .SEQ_WIDTH(SW), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .cfg_decim(cfg_decim), .cfg_accum(cfg_accum), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .timeout_count(timeout_count), .dup_count(dup_count), .drop_count(drop_count));

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [DW-1:0] data; logic last; } word_t;
  word_t got_q[$];
  word_t exp_q[$];

  typedef struct {
    logic [7:0] decim; logic accum; int sets;
    logic [DW-1:0] base, step;
    logic [7:0] exp_dec; logic [DW-1:0] exp_base, exp_step;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: records handshaked words, checks stability under stall
  logic stall_p = 1'b0;
  logic [DW-1:0] d_p;
  logic l_p;
  always @(negedge aclk) begin
    if (!areset) begin
      if (stall_p) check("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, l_p, d_p});
      if (m_axis_tvalid && m_axis_tready) got_q.push_back('{m_axis_tdata, m_axis_tlast});
    end
    stall_p = m_axis_tvalid && !m_axis_tready && !areset;
    d_p = m_axis_tdata;
    l_p = m_axis_tlast;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_tvalid = '0;
    tick();
    tick();
    areset = 1'b0;
    got_q.delete();
  endtask

  task automatic drive_set(input logic [DW-1:0] base, input logic [DW-1:0] step,
                           input logic [N_CH-1:0] mask);
    for (int i = 0; i < N_CH; i++) s_tdata[i*DW +: DW] = base + DW'(i) * step;
    s_tvalid = mask;
    tick();
    s_tvalid = '0;
  endtask

  task automatic expect_frame(input string name, input logic [SW-1:0] seq, input logic [7:0] dec,
                              input logic [DW-1:0] eb, input logic [DW-1:0] es, input bit tog);
    int n;
    word_t w;
    logic [DW-1:0] hdr;
    n = 0;
    while (got_q.size() < N_CH + 1 && n < 400) begin
      tick();
      if (tog) m_axis_tready = !m_axis_tready;
      n++;
    end
    m_axis_tready = 1'b1;
    check({name, "_arrived"}, 64'(got_q.size() >= N_CH + 1), 64'd1);
    if (got_q.size() >= N_CH + 1) begin
      hdr = {seq, 8'h00, dec};
      w = got_q.pop_front();
      check({name, "_hdr"}, w.data, hdr);
      check({name, "_hdr_last"}, w.last, 0);
      for (int i = 0; i < N_CH; i++) begin
        w = got_q.pop_front();
        check({name, "_word"}, w.data, eb + DW'(i) * es);
        check({name, "_last"}, w.last, (i == N_CH - 1));
      end
    end
  endtask

  // Reference model: tracks open set, group progress and output occupancy
  bit              m_pend[N_CH];
  longint unsigned m_hold[N_CH];
  int m_setcnt, m_dlat, m_open, m_cyc, m_busy, m_seq, m_tmo, m_dup, m_drop;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin m_pend[i] = 0; m_hold[i] = 0; end
    m_setcnt = 0; m_dlat = 1; m_open = 0; m_cyc = 0; m_busy = 0;
    m_seq = 0; m_tmo = 0; m_dup = 0; m_drop = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit complete, tmo, anyp, anyv, first, busy_pre;
    longint unsigned s;
    anyp = 0; anyv = 0; complete = 1;
    for (int i = 0; i < N_CH; i++) begin
      anyp |= m_pend[i];
      anyv |= s_tvalid[i];
      if (!(m_pend[i] || s_tvalid[i])) complete = 0;
      if (s_tvalid[i] && m_pend[i] && m_dup < 65535) m_dup++;
    end
    tmo = !complete && anyp && (m_cyc - m_open == TMO);
    busy_pre = (m_busy > 0);
    if (busy_pre && m_axis_tready) m_busy--;
    if (m_setcnt == 0) m_dlat = (cfg_decim == 0) ? 1 : int'(cfg_decim);
    first = !cfg_accum || m_setcnt == 0 || tmo;
    for (int i = 0; i < N_CH; i++) begin
      if (s_tvalid[i]) begin
        s = first ? longint'(s_tdata[i*DW +: DW]) : m_hold[i] + longint'(s_tdata[i*DW +: DW]);
        m_hold[i] = (s > MAXV) ? MAXV : s;
      end
    end
    if (complete) begin
      for (int i = 0; i < N_CH; i++) m_pend[i] = 0;
      m_setcnt++;
      if (m_setcnt == m_dlat) begin
        m_setcnt = 0;
        if (busy_pre) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          exp_q.push_back('{{16'(m_seq), 8'h00, 8'(m_dlat)}, 1'b0});
          for (int i = 0; i < N_CH; i++) exp_q.push_back('{32'(m_hold[i]), (i == N_CH - 1)});
          m_busy = N_CH + 1;
        end
        m_seq = (m_seq + 1) % 65536;
      end
    end else if (tmo) begin
      if (m_tmo < 65535) m_tmo++;
      m_setcnt = 0;
      for (int i = 0; i < N_CH; i++) m_pend[i] = s_tvalid[i];
      m_open = m_cyc;
    end else begin
      if (!anyp && anyv) m_open = m_cyc;
      for (int i = 0; i < N_CH; i++) m_pend[i] |= s_tvalid[i];
    end
    m_cyc++;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w, e;
    int n;
    areset = 1'b1; s_tvalid = '0; s_tdata = '0;
    cfg_decim = 8'd1; cfg_accum = 1'b0; m_axis_tready = 1'b1;

    vecs[0] = '{decim:8'd1, accum:1'b0, sets:1, base:32'd1,         step:32'd1,    exp_dec:8'd1, exp_base:32'd1,          exp_step:32'd1};
    vecs[1] = '{decim:8'd4, accum:1'b1, sets:4, base:32'h4000_0000, step:32'd0,    exp_dec:8'd4, exp_base:32'hFFFF_FFFF, exp_step:32'd0};
    vecs[2] = '{decim:8'd0, accum:1'b0, sets:1, base:32'h100,       step:32'h10,   exp_dec:8'd1, exp_base:32'h100,        exp_step:32'h10};
    vecs[3] = '{decim:8'd3, accum:1'b1, sets:3, base:32'd5,         step:32'd2,    exp_dec:8'd3, exp_base:32'd15,         exp_step:32'd6};
    vecs[4] = '{decim:8'd2, accum:1'b0, sets:2, base:32'd7,         step:32'd3,    exp_dec:8'd2, exp_base:32'd7,          exp_step:32'd3};
    vecs[5] = '{decim:8'd2, accum:1'b1, sets:2, base:32'h8000_0000, step:32'd0,    exp_dec:8'd2, exp_base:32'hFFFF_FFFF, exp_step:32'd0};

    tick(); tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_timeout_count", timeout_count, 0);
    check("rst_dup_count", dup_count, 0);
    check("rst_drop_count", drop_count, 0);
    areset = 1'b0;
    got_q.delete();

    // table-driven frames, seq counting up from 0
    for (int v = 0; v < 6; v++) begin
      cfg_decim = vecs[v].decim;
      cfg_accum = vecs[v].accum;
      for (int s = 0; s < vecs[v].sets; s++) begin
        check("no_early_frame", m_axis_tvalid, 0);
        drive_set(vecs[v].base, vecs[v].step, '1);
      end
      @(negedge aclk);
      check("latency_tvalid", m_axis_tvalid, 1);
      expect_frame("vec", 16'(v), vecs[v].exp_dec, vecs[v].exp_base, vecs[v].exp_step, 1'b0);
    end

    // skewed valids with toggling back-pressure
    cfg_decim = 8'd1; cfg_accum = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic [N_CH-1:0] mask;
      mask = '0;
      for (int i = 0; i < N_CH; i++) mask[i] = (i % 5 == c);
      drive_set(32'h1000, 32'h11, mask);
      m_axis_tready = !m_axis_tready;
    end
    expect_frame("skew", 16'd0, 8'd1, 32'h1000, 32'h11, 1'b1);
    check("skew_dup_count", dup_count, 0);
    check("skew_extra_words", got_q.size(), 0);

    // timeout discards partial set
    do_reset();
    drive_set(32'hAA, 32'd1, 8'h7F);
    for (int c = 0; c < TMO + 4; c++) tick();
    check("tmo_no_frame", got_q.size() + int'(m_axis_tvalid), 0);
    check("tmo_count", timeout_count, 1);
    drive_set(32'h55, 32'd2, '1);
    expect_frame("tmo_after", 16'd0, 8'd1, 32'h55, 32'd2, 1'b0);

    // completion at the exact timeout cycle wins over the timeout
    do_reset();
    drive_set(32'h300, 32'd4, 8'h7F);
    for (int c = 0; c < TMO - 1; c++) tick();
    drive_set(32'h300, 32'd4, 8'h80);
    expect_frame("tmo_edge", 16'd0, 8'd1, 32'h300, 32'd4, 1'b0);
    check("tmo_edge_count", timeout_count, 0);

    // drop while busy leaves a sequence gap
    do_reset();
    m_axis_tready = 1'b0;
    drive_set(32'h10, 32'd1, '1);
    tick();
    drive_set(32'h90, 32'd1, '1);
    check("drop_count", drop_count, 1);
    check("drop_tdata_held", m_axis_tdata, {16'd0, 8'h00, 8'd1});
    m_axis_tready = 1'b1;
    expect_frame("drop_first", 16'd0, 8'd1, 32'h10, 32'd1, 1'b0);
    drive_set(32'h20, 32'd1, '1);
    expect_frame("drop_next", 16'd2, 8'd1, 32'h20, 32'd1, 1'b0);

    // reset mid-frame after header handshake
    do_reset();
    drive_set(32'h7, 32'd0, 8'h01);
    drive_set(32'h7, 32'd0, 8'h01);
    drive_set(32'h7, 32'd0, '1);
    check("mid_dup_count", dup_count, 2);
    tick();
    areset = 1'b1;
    tick();
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    check("mid_rst_dup", dup_count, 0);
    areset = 1'b0;
    got_q.delete();
    drive_set(32'h40, 32'd8, '1);
    expect_frame("mid_after", 16'd0, 8'd1, 32'h40, 32'd8, 1'b0);
    check("mid_after_counters", {timeout_count, dup_count, drop_count}, 0);

    // randomized run against the reference model
    cfg_decim = 8'd1; cfg_accum = 1'b0;
    do_reset();
    model_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int p;
      int starve;
      cfg_accum = 1'($urandom_range(1));
      p = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 60 : 95;
      starve = (ph % 4 == 3) ? int'($urandom_range(N_CH - 1)) : -1;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(49) == 0) cfg_decim = 8'($urandom_range(3));
        for (int i = 0; i < N_CH; i++) begin
          s_tvalid[i] = (int'($urandom_range(99)) < ((i == starve) ? 1 : p));
          s_tdata[i*DW +: DW] = ($urandom_range(3) == 0) ? (32'hC000_0000 | $urandom) : $urandom;
        end
        m_axis_tready = ($urandom_range(9) < 7);
        model_step();
        tick();
      end
    end
    s_tvalid = '0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      model_step();
      tick();
    end
    check("rand_word_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      w = got_q.pop_front();
      e = exp_q.pop_front();
      check("rand_data", w.data, e.data);
      check("rand_last", w.last, e.last);
    end
    check("rand_timeout_count", timeout_count, m_tmo);
    check("rand_dup_count", dup_count, m_dup);
    check("rand_drop_count", drop_count, m_drop);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
